// File: rtl/pc_ifid_stage_pkg.sv
// Shared types and constants for the PC / IF-ID fetch stage.
`default_nettype none

package pc_ifid_stage_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ifid_stage_next_pc_sel.sv
// Next-PC selection (hold, +4 or redirect target) and per-cycle action decode.
`default_nettype none

module next_pc_sel
  import pc_ifid_stage_pkg::*;
(
  input  state_t      state,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        capture,
  output logic        flush,
  output logic        misaligned
);

  always_comb begin
    next_pc    = pc;
    capture    = 1'b0;
    flush      = 1'b0;
    misaligned = 1'b0;
    // TRAP ignores every input: all outputs keep their hold defaults.
    if (state == RUN) begin
      if (redirect_valid) begin
        flush = 1'b1;
        if (is_word_aligned(redirect_target)) begin
          next_pc = redirect_target;
        end else begin
          misaligned = 1'b1;
        end
      end else if (!stall) begin
        next_pc = pc + 32'd4;
        capture = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_ifid_stage.sv
// Program counter and IF/ID pipeline register with redirect, stall and
// misaligned-redirect trap handling. All state lives here.
`default_nettype none

module pc_ifid_stage
  import pc_ifid_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        trap_o,
  output logic [31:0] fetch_count_o
);

  state_t      state;
  logic [31:0] next_pc;
  logic        capture;
  logic        flush;
  logic        misaligned;

  next_pc_sel u_next_pc_sel (
    .state           (state),
    .stall           (stall_i),
    .redirect_valid  (redirect_valid_i),
    .redirect_target (redirect_target_i),
    .pc              (pc_o),
    .next_pc         (next_pc),
    .capture         (capture),
    .flush           (flush),
    .misaligned      (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc_o          <= RESET_PC;
      ifid_pc_o     <= 32'h0000_0000;
      ifid_instr_o  <= NOP_INSTR;
      ifid_valid_o  <= 1'b0;
      trap_o        <= 1'b0;
      fetch_count_o <= 32'h0000_0000;
    end else begin
      pc_o <= next_pc;
      if (capture) begin
        ifid_pc_o     <= pc_o;
        ifid_instr_o  <= instr_i;
        ifid_valid_o  <= 1'b1;
        fetch_count_o <= fetch_count_o + 32'd1;
      end else if (flush) begin
        // Flush keeps ifid_pc_o so the bubble still carries its last PC.
        ifid_instr_o <= NOP_INSTR;
        ifid_valid_o <= 1'b0;
      end
      if (misaligned) begin
        state  <= TRAP;
        trap_o <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_ifid_stage.sv
// Directed, table-driven self-checking bench for pc_ifid_stage.
`default_nettype none

module tb_pc_ifid_stage;
  import pc_ifid_stage_pkg::*;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] MEM_SALT = 32'hC0DE_0000;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        valid;
    logic        trap;
    logic [31:0] count;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        rv;
  logic [31:0] tgt;
  logic [31:0] instr;
  logic [31:0] pc, ifid_pc, ifid_instr, count;
  logic        valid, trap;

  logic        reset_w;
  logic [31:0] instr_w;
  logic [31:0] pc_w, ifid_pc_w, ifid_instr_w, count_w;
  logic        valid_w, trap_w;

  int errors = 0;
  int checks = 0;
  vec_t vecs[10];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ MEM_SALT;
  endfunction

  assign instr   = mem(pc);
  assign instr_w = mem(pc_w);

  pc_ifid_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall),
    .redirect_valid_i  (rv),
    .redirect_target_i (tgt),
    .instr_i           (instr),
    .pc_o              (pc),
    .ifid_pc_o         (ifid_pc),
    .ifid_instr_o      (ifid_instr),
    .ifid_valid_o      (valid),
    .trap_o            (trap),
    .fetch_count_o     (count)
  );

  pc_ifid_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk               (clk),
    .reset             (reset_w),
    .stall_i           (1'b0),
    .redirect_valid_i  (1'b0),
    .redirect_target_i (32'h0000_0000),
    .instr_i           (instr_w),
    .pc_o              (pc_w),
    .ifid_pc_o         (ifid_pc_w),
    .ifid_instr_o      (ifid_instr_w),
    .ifid_valid_o      (valid_w),
    .trap_o            (trap_w),
    .fetch_count_o     (count_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                         input logic [31:0] e_ins, input logic e_v, input logic e_t,
                         input logic [31:0] e_cnt);
    chk({tag, ".pc"},         pc,                 e_pc);
    chk({tag, ".ifid_pc"},    ifid_pc,            e_ipc);
    chk({tag, ".ifid_instr"}, ifid_instr,         e_ins);
    chk({tag, ".valid"},      {31'd0, valid},     {31'd0, e_v});
    chk({tag, ".trap"},       {31'd0, trap},      {31'd0, e_t});
    chk({tag, ".count"},      count,              e_cnt);
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall = s;
    rv    = r;
    tgt   = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // stall, rv, tgt | pc, ifid_pc, ifid_instr, valid, trap, count
    vecs[0] = '{0, 0, 32'h0,  32'h04, 32'h00, mem(32'h00), 1, 0, 1};
    vecs[1] = '{0, 0, 32'h0,  32'h08, 32'h04, mem(32'h04), 1, 0, 2};
    vecs[2] = '{1, 0, 32'h0,  32'h08, 32'h04, mem(32'h04), 1, 0, 2};
    vecs[3] = '{1, 0, 32'h0,  32'h08, 32'h04, mem(32'h04), 1, 0, 2};
    vecs[4] = '{0, 0, 32'h0,  32'h0C, 32'h08, mem(32'h08), 1, 0, 3};
    vecs[5] = '{0, 0, 32'h0,  32'h10, 32'h0C, mem(32'h0C), 1, 0, 4};
    vecs[6] = '{1, 1, 32'h40, 32'h40, 32'h0C, NOP,         0, 0, 4};
    vecs[7] = '{0, 0, 32'h0,  32'h44, 32'h40, mem(32'h40), 1, 0, 5};
    vecs[8] = '{0, 0, 32'h0,  32'h48, 32'h44, mem(32'h44), 1, 0, 6};
    vecs[9] = '{0, 1, 32'h42, 32'h48, 32'h44, NOP,         0, 1, 6};

    reset = 1'b1; reset_w = 1'b1;
    stall = 1'b0; rv = 1'b0; tgt = 32'h0;
    @(posedge clk); #1;
    chk_all("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].stall, vecs[i].rv, vecs[i].tgt);
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ifid_pc, vecs[i].ifid_instr,
              vecs[i].valid, vecs[i].trap, vecs[i].count);
    end

    // Trap is sticky: redirects (aligned and not) and stalls are ignored.
    for (int i = 0; i < 10; i++) begin
      step(i[0], 1'b1, (i[1] ? 32'h80 : 32'h81));
      chk_all($sformatf("trap%0d", i), 32'h48, 32'h44, NOP, 1'b0, 1'b1, 32'h6);
    end

    // Reset clears the trap even with a redirect and stall pending.
    reset = 1'b1;
    step(1'b1, 1'b1, 32'h100);
    chk_all("trap_reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;

    // Run up to pc=0x10, then a one-cycle reset mid-stream.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    chk_all("pre_mid", 32'h10, 32'h0C, mem(32'h0C), 1'b1, 1'b0, 32'h4);
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    chk_all("mid_reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    chk_all("post_mid", 32'h4, 32'h0, mem(32'h0), 1'b1, 1'b0, 32'h1);

    // PC wraps modulo 2^32 from a high reset vector.
    @(posedge clk); #1;
    chk("wrap.rst_pc", pc_w, 32'hFFFF_FFFC);
    reset_w = 1'b0;
    @(posedge clk); #1;
    chk("wrap.pc1",      pc_w,      32'h0000_0000);
    chk("wrap.ifid_pc1", ifid_pc_w, 32'hFFFF_FFFC);
    chk("wrap.instr1",   ifid_instr_w, mem(32'hFFFF_FFFC));
    chk("wrap.valid1",   {31'd0, valid_w}, 32'd1);
    chk("wrap.count1",   count_w,   32'd1);
    @(posedge clk); #1;
    chk("wrap.pc2",      pc_w,      32'h0000_0004);
    chk("wrap.ifid_pc2", ifid_pc_w, 32'h0000_0000);
    chk("wrap.trap2",    {31'd0, trap_w}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
